// File: rtl/ascon_init_controller.sv
// ASCON initialization sequencer: builds S0, runs NB_ROUNDS_A external rounds, applies the closing key XOR.
// Optional ASCON_KEYLEN_CHECK_EN: k=0 or k>KEY_MAX skips the rounds and reports a zero state.
module ascon_init_controller #(
  parameter int NB_ROUNDS_A = 12,
  parameter int KEY_MAX     = 160
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [7:0]   key_lenght_k_i,
  input  logic [191:0] initialisation_vector_i,
  input  logic [159:0] key_i,
  input  logic [127:0] nonce_i,
  output logic         perm_en_o,
  output logic [3:0]   perm_round_o,
  output logic [319:0] perm_state_o,
  input  logic [319:0] perm_state_i,
  output logic [319:0] state_o,
  output logic         done_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] FIRST_RND = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] LAST_CNT  = 4'(NB_ROUNDS_A - 1);

  if (NB_ROUNDS_A < 1 || NB_ROUNDS_A > 12 || KEY_MAX < 1 || KEY_MAX > 160) begin : g_param_check
    $error("ascon_init_controller: NB_ROUNDS_A or KEY_MAX out of range");
  end

  state_t       r_fsm;
  logic [319:0] r_state;
  logic [159:0] r_key_m;
  logic [3:0]   r_cnt;
  logic         r_ready;
  logic         r_busy;
  logic         r_done;
  logic         r_perm_en;
  logic [3:0]   r_perm_round;

  logic [191:0] w_ones;
  logic [191:0] w_iv_keep;
  logic [191:0] w_iv_org;
  logic [191:0] w_key_m;
  logic [319:0] w_s0;
  logic         w_k_bad;

  // IV bits that would be shifted past bit 191 are cleared before the shift.
  assign w_ones    = '1;
  assign w_iv_keep = (key_lenght_k_i >= 8'd192) ? '0 : ~(w_ones << (8'd192 - key_lenght_k_i));
  assign w_iv_org  = (initialisation_vector_i & w_iv_keep) << key_lenght_k_i;
  assign w_key_m   = {32'd0, key_i} & ~(w_ones << key_lenght_k_i);
  assign w_s0      = {w_iv_org | w_key_m, nonce_i};

`ifdef ASCON_KEYLEN_CHECK_EN
  assign w_k_bad = (key_lenght_k_i == 8'd0) || (32'(key_lenght_k_i) > 32'(KEY_MAX));
`else
  assign w_k_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fsm        <= IDLE;
      r_state      <= '0;
      r_key_m      <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_perm_en    <= 1'b0;
      r_perm_round <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (start_i) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_key_m <= w_key_m[159:0];
            if (w_k_bad) begin
              r_state <= '0;
              r_done  <= 1'b1;
              r_fsm   <= DONE;
            end else begin
              r_state      <= w_s0;
              r_perm_en    <= 1'b1;
              r_perm_round <= FIRST_RND;
              r_fsm        <= ROUND;
            end
          end
        end
        ROUND: begin
          r_state <= perm_state_i;
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            r_perm_en    <= 1'b0;
            r_perm_round <= '0;
            r_fsm        <= FINAL;
          end else begin
            r_perm_round <= r_perm_round + 4'd1;
          end
        end
        FINAL: begin
          r_state <= r_state ^ {160'd0, r_key_m};
          r_done  <= 1'b1;
          r_fsm   <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_fsm   <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign ready_o      = r_ready;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign perm_en_o    = r_perm_en;
  assign perm_round_o = r_perm_round;
  assign perm_state_o = r_state;
  assign state_o      = r_state;

endmodule
